// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder: the FSM state encoding,
// the width of the latency down-counter, and the default geometry and latency.
// No ports; imported by dmem_array and dmem_responder.

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Data-memory request interface between the CPU MEM stage and the responder.
// The master is the pipeline (EX/MEM register side). The slave is the responder.
//   MemRead_i  : read request
//   MemWrite_i : write request
//   addr_i     : byte address
//   data_i     : write data
//   data_o     : registered read data
//   stall_o    : pipeline hold while an access is outstanding
//   err_o      : sticky access-error flag (constant 0 unless DMEM_ERR_CHECK_EN)

interface dmem_responder_if;

  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, data_i,
    input  data_o, stall_o, err_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, data_i,
    output data_o, stall_o, err_o
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array
// Single-port synchronous word RAM with a registered read port.
//   clk   : clock
//   rst   : synchronous active-high reset; clears only the read register
//   we    : write wdata into mem[index] at the rising edge
//   re    : load rdata from mem[index] at the rising edge
//   index : word index
//   wdata : write data
//   rdata : registered read data; holds its value between reads
// The storage itself is never cleared by reset.

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage of the pipeline.
// A request seen in IDLE is latched. The FSM then spends LATENCY cycles in BUSY.
// The access happens on the last BUSY edge. DONE lasts one cycle and releases
// the pipeline.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   mem   : dmem_responder_if.slave (request, read data, stall, error)
// Optional feature: define DMEM_ERR_CHECK_EN to enable the sticky err_o check.
// The check flags misaligned addresses, out-of-range addresses and requests
// with both read and write high. When the macro is undefined, err_o is tied 0.

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  mem
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               rd_q;
  logic               wr_q;
  logic               req;
  logic               fire;
  logic               we;
  logic               re;

  assign req  = mem.MemRead_i | mem.MemWrite_i;
  assign fire = (state == BUSY) && (cnt == '0);

  // A write that is in flight when reset arrives must not reach the array.
  // When read and write are both high, only the write is performed.
  assign we = fire && wr_q && !rst_i;
  assign re = fire && rd_q && !wr_q;

  // Accept and latch the request in IDLE, count down in BUSY, and release in DONE.
  // DONE always returns to IDLE, so the request still visible there is not
  // accepted a second time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= mem.addr_i[IDX_W+1:2];
            wdata_q <= mem.data_i;
            rd_q    <= mem.MemRead_i;
            wr_q    <= mem.MemWrite_i;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // In IDLE, stall is raised combinationally so the pipeline holds in the same
  // cycle that the request first appears.
  always_comb begin
    mem.stall_o = 1'b0;
    case (state)
      IDLE:    mem.stall_o = req;
      BUSY:    mem.stall_o = 1'b1;
      DONE:    mem.stall_o = 1'b0;
      default: mem.stall_o = 1'b0;
    endcase
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (we),
    .re    (re),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (mem.data_o)
  );

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;
  logic bad_req;

  assign bad_req = (mem.addr_i[1:0] != 2'b00)
                || (|(mem.addr_i >> (IDX_W + 2)))
                || (mem.MemRead_i && mem.MemWrite_i);

  // The error is sampled only at the accept edge and stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && req && bad_req) begin
      err_q <= 1'b1;
    end
  end

  assign mem.err_o = err_q;
`else
  logic unused_addr_bits;

  assign mem.err_o        = 1'b0;
  assign unused_addr_bits = ^{mem.addr_i[31:IDX_W+2], mem.addr_i[1:0]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Scoreboard bench for dmem_responder with DEPTH=256 and LATENCY=2.
// For each directed access, the stimulus side pushes the hand-computed data_o
// value expected in its DONE cycle. A negedge monitor detects DONE as a falling
// stall_o and pops the queue. It then checks data_o and the length of the stall
// that preceded it.

module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  dmem_responder_if mem ();

  dmem_responder #(
    .DEPTH   (256),
    .LATENCY (LAT)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mem   (mem)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: count stall cycles and compare against the scoreboard when DONE appears.
  int stall_run  = 0;
  bit prev_stall = 1'b0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_run  = 0;
      prev_stall = 1'b0;
    end else if (mem.stall_o) begin
      stall_run++;
      prev_stall = 1'b1;
    end else if (prev_stall) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got a completion, expected none queued");
      end else begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        check_output({e.name, " data_o"}, mem.data_o, e.data);
        check_output({e.name, " stall_len"}, 32'(stall_run), 32'(LAT + 1));
      end
      stall_run  = 0;
      prev_stall = 1'b0;
    end
  end

  // Issue one access and hold it until DONE. The task returns at posedge+1 after
  // the DONE edge.
  task automatic apply_stimulus(input string name, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_data);
    bit done;
    sb.push_back('{name, exp_data});
    mem.MemRead_i  = rd;
    mem.MemWrite_i = wr;
    mem.addr_i     = addr;
    mem.data_i     = wdata;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (!mem.stall_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: got stall_o stuck high, expected DONE within 40 cycles", name);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Keep the request low and check that nothing moves.
  task automatic idle_cycles(input string name, input int n, input logic [31:0] exp_data);
    mem.MemRead_i  = 1'b0;
    mem.MemWrite_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_output({name, " stall_o"}, {31'd0, mem.stall_o}, 32'd0);
      check_output({name, " data_o"}, mem.data_o, exp_data);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] exp_err;

  initial begin
    rst_i          = 1'b1;
    mem.MemRead_i  = 1'b0;
    mem.MemWrite_i = 1'b0;
    mem.addr_i     = '0;
    mem.data_i     = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check_output("reset stall_o", {31'd0, mem.stall_o}, 32'd0);
    check_output("reset data_o", mem.data_o, 32'd0);
    check_output("reset err_o", {31'd0, mem.err_o}, 32'd0);
    @(posedge clk_i);
    #1;

    // Basic write followed by a read. A write leaves data_o unchanged.
    apply_stimulus("wr_pre20", 1'b0, 1'b1, 32'h20, 32'h0000_0011, 32'h0);
    apply_stimulus("wr_dead",  1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
    apply_stimulus("rd_dead",  1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF);

    // Back-to-back reads with zero gap.
    apply_stimulus("wr_w0", 1'b0, 1'b1, 32'h00, 32'h1, 32'hDEAD_BEEF);
    apply_stimulus("wr_w1", 1'b0, 1'b1, 32'h04, 32'h2, 32'hDEAD_BEEF);
    apply_stimulus("rd_w0", 1'b1, 1'b0, 32'h00, 32'h0, 32'h1);
    apply_stimulus("rd_w1", 1'b1, 1'b0, 32'h04, 32'h0, 32'h2);
    check_output("err_after_aligned", {31'd0, mem.err_o}, 32'd0);

    // Reset during the second BUSY cycle of a write aborts that write.
    mem.MemRead_i  = 1'b0;
    mem.MemWrite_i = 1'b1;
    mem.addr_i     = 32'h20;
    mem.data_i     = 32'h55;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i          = 1'b0;
    mem.MemWrite_i = 1'b0;
    @(negedge clk_i);
    check_output("abort stall_o", {31'd0, mem.stall_o}, 32'd0);
    check_output("abort data_o", mem.data_o, 32'd0);
    @(posedge clk_i);
    #1;
    apply_stimulus("rd_20_after_abort", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11);

    // Addresses wrap modulo DEPTH*4.
    apply_stimulus("wr_wrap", 1'b0, 1'b1, 32'h400, 32'hA5, 32'h11);
    apply_stimulus("rd_wrap", 1'b1, 1'b0, 32'h000, 32'h0,  32'hA5);

    idle_cycles("idle10", 10, 32'hA5);

    // Read and write together: the write wins, and data_o is unchanged.
    apply_stimulus("wr_both", 1'b1, 1'b1, 32'h08, 32'h77, 32'hA5);
    apply_stimulus("rd_both", 1'b1, 1'b0, 32'h08, 32'h0,  32'h77);

    // Clear the sticky error, then read a misaligned address (word 0 = 0xA5).
    mem.MemRead_i  = 1'b0;
    mem.MemWrite_i = 1'b0;
    rst_i          = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_output("err_cleared", {31'd0, mem.err_o}, 32'd0);
    check_output("reset2 data_o", mem.data_o, 32'd0);
    @(posedge clk_i);
    #1;
    apply_stimulus("rd_unaligned", 1'b1, 1'b0, 32'h3, 32'h0, 32'hA5);
    idle_cycles("idle_after_err", 3, 32'hA5);
`ifdef DMEM_ERR_CHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif
    check_output("err_sticky", {31'd0, mem.err_o}, exp_err);

    repeat (2) @(posedge clk_i);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
